// File: rtl/issue_select_pkg.sv
// Shared scheduler types for the issue/select stage: FU identifiers and latency fields.
package issue_select_pkg;

  localparam int NUM_FUS = 4;
  localparam int LAT_W   = 8;

  typedef logic [$clog2(NUM_FUS)-1:0] fu_id_t;
  typedef logic [LAT_W-1:0]           lat_t;

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// Round-robin picker: first requesting index at or above ptr, wrapping around.
module rr_arbiter
  import issue_select_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int ofs);
    return IDX_W'((int'(base) + ofs) % N);
  endfunction

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid && req[wrap_idx(ptr, i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap_idx(ptr, i);
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Scheduler select stage: per-FU round-robin grant, latency-timed column clear and free-row return.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = issue_select_pkg::NUM_FUS,
  parameter int LAT_W    = issue_select_pkg::LAT_W
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0]               alloc_row,
  input  fu_id_t                                    alloc_fu,
  input  logic [LAT_W-1:0]                          alloc_lat,
  input  logic [NUM_ROWS-1:0]                       request_vector,
  output logic [NUM_FUS-1:0]                        grant_valid,
  output logic [NUM_FUS-1:0][$clog2(NUM_ROWS)-1:0]  grant_row,
  input  logic [NUM_FUS-1:0]                        fu_ready,
  output logic                                      clear_en,
  output logic [NUM_ROWS-1:0]                       clear_lines,
  output logic                                      free_en,
  output logic [$clog2(NUM_ROWS)-1:0]               free_row_index
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int CNT_W = $clog2(NUM_ROWS + 1);

  function automatic logic [LAT_W-1:0] norm_lat(input logic [LAT_W-1:0] l);
    return (l == '0) ? LAT_W'(1) : l;
  endfunction

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (int'(r) == NUM_ROWS - 1) ? '0 : r + 1'b1;
  endfunction

  fu_id_t                              fu_tab  [NUM_ROWS];
  logic [LAT_W-1:0]                    lat_tab [NUM_ROWS];
  logic [NUM_ROWS-1:0]                 issued;
  logic [NUM_FUS-1:0][ROW_W-1:0]       rr_ptr;
  logic [NUM_FUS-1:0][LAT_W-1:0]       busy_cnt;
  logic [NUM_FUS-1:0][LAT_W-1:0]       busy_nxt;
  logic [NUM_FUS-1:0][ROW_W-1:0]       busy_tag;
  logic [NUM_FUS-1:0]                  hs;
  logic [NUM_FUS-1:0]                  pick;
  logic [NUM_FUS-1:0]                  arb_valid;
  logic [NUM_FUS-1:0][ROW_W-1:0]       arb_idx;
  logic [NUM_FUS-1:0][NUM_ROWS-1:0]    arb_req;
  logic [ROW_W-1:0]                    fq_mem  [NUM_ROWS];
  logic [ROW_W-1:0]                    fq_head;
  logic [CNT_W-1:0]                    fq_cnt;
  logic [NUM_FUS-1:0][ROW_W-1:0]       push_slot;
  logic                                fq_pop;
  int                                  push_cnt;
  int                                  fq_occ_nxt;

  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      hs[f] = grant_valid[f] & fu_ready[f];
      if (hs[f])
        busy_nxt[f] = lat_tab[grant_row[f]];
      else if (busy_cnt[f] != '0)
        busy_nxt[f] = busy_cnt[f] - 1'b1;
      else
        busy_nxt[f] = '0;
      for (int r = 0; r < NUM_ROWS; r++)
        arb_req[f][r] = request_vector[r] & ~issued[r] & (fu_tab[r] == fu_id_t'(f));
    end
  end

  for (genvar f = 0; f < NUM_FUS; f++) begin : g_arb
    rr_arbiter #(.N(NUM_ROWS)) u_arb (
      .req       (arb_req[f]),
      .ptr       (rr_ptr[f]),
      .gnt_valid (arb_valid[f]),
      .gnt_idx   (arb_idx[f])
    );
  end

  // A new grant is allowed when the count the FU will hold as it becomes visible is at most 1,
  // so the follow-on issue can handshake in the previous op's clear cycle.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++)
      pick[f] = arb_valid[f] & (~grant_valid[f] | hs[f]) & (busy_nxt[f] <= LAT_W'(1));
  end

  always_comb begin
    clear_lines = '0;
    for (int f = 0; f < NUM_FUS; f++)
      if (busy_cnt[f] == LAT_W'(1))
        clear_lines[busy_tag[f]] = 1'b1;
  end

  assign clear_en = |clear_lines;

  // Handshaking rows land after the current tail in ascending FU order.
  always_comb begin
    push_cnt = 0;
    for (int f = 0; f < NUM_FUS; f++) begin
      push_slot[f] = ROW_W'((int'(fq_head) + int'(fq_cnt) + push_cnt) % NUM_ROWS);
      push_cnt     = push_cnt + (hs[f] ? 1 : 0);
    end
    fq_pop     = (fq_cnt != '0);
    fq_occ_nxt = int'(fq_cnt) + push_cnt - (fq_pop ? 1 : 0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      grant_valid    <= '0;
      grant_row      <= '0;
      rr_ptr         <= '0;
      busy_cnt       <= '0;
      busy_tag       <= '0;
      issued         <= '0;
      fq_head        <= '0;
      fq_cnt         <= '0;
      free_en        <= 1'b0;
      free_row_index <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        fu_tab[r]  <= '0;
        lat_tab[r] <= '0;
        fq_mem[r]  <= '0;
      end
    end else begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (pick[f]) begin
          grant_valid[f]      <= 1'b1;
          grant_row[f]        <= arb_idx[f];
          rr_ptr[f]           <= next_row(arb_idx[f]);
          issued[arb_idx[f]]  <= 1'b1;
        end else if (hs[f]) begin
          grant_valid[f] <= 1'b0;
        end
        busy_cnt[f] <= busy_nxt[f];
        if (hs[f]) begin
          busy_tag[f]          <= grant_row[f];
          fq_mem[push_slot[f]] <= grant_row[f];
        end
      end
      if (alloc_en) begin
        fu_tab[alloc_row]  <= alloc_fu;
        lat_tab[alloc_row] <= norm_lat(alloc_lat);
        issued[alloc_row]  <= 1'b0;
      end
      free_en        <= fq_pop;
      free_row_index <= fq_pop ? fq_mem[fq_head] : '0;
      fq_head        <= fq_pop ? next_row(fq_head) : fq_head;
      fq_cnt         <= CNT_W'(fq_occ_nxt);
    end
  end

  a_fq_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    fq_occ_nxt <= NUM_ROWS);

  for (genvar f = 0; f < NUM_FUS; f++) begin : g_chk
    a_no_reissue: assert property (@(posedge clk) disable iff (rst || flush)
      pick[f] |-> !issued[arb_idx[f]]);
    a_grant_stable: assert property (@(posedge clk) disable iff (rst)
      (grant_valid[f] && !fu_ready[f] && !flush) |=> (grant_valid[f] && $stable(grant_row[f])));
    for (genvar g = f + 1; g < NUM_FUS; g++) begin : g_pair
      a_unique_row: assert property (@(posedge clk) disable iff (rst)
        !(grant_valid[f] && grant_valid[g] && grant_row[f] == grant_row[g]));
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios with literal expectations plus a random phase
// checked every cycle against an event-time model of grants, clears and free returns.
module tb_issue_select;
  import issue_select_pkg::*;

  localparam int NR = 8;
  localparam int NF = 4;
  localparam int LW = 8;
  localparam int RW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, flush, alloc_en;
  logic [RW-1:0]          alloc_row;
  fu_id_t                 alloc_fu;
  logic [LW-1:0]          alloc_lat;
  logic [NR-1:0]          request_vector;
  logic [NF-1:0]          grant_valid;
  logic [NF-1:0][RW-1:0]  grant_row;
  logic [NF-1:0]          fu_ready;
  logic                   clear_en;
  logic [NR-1:0]          clear_lines;
  logic                   free_en;
  logic [RW-1:0]          free_row_index;

  issue_select #(.NUM_ROWS(NR), .NUM_FUS(NF), .LAT_W(LW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en), .alloc_row(alloc_row),
    .alloc_fu(alloc_fu), .alloc_lat(alloc_lat), .request_vector(request_vector),
    .grant_valid(grant_valid), .grant_row(grant_row), .fu_ready(fu_ready),
    .clear_en(clear_en), .clear_lines(clear_lines), .free_en(free_en),
    .free_row_index(free_row_index)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a grant may become visible once the FU's previous clear cycle has arrived.
  bit  m_on = 1'b0;
  int  m_cyc = 0;
  bit  m_gv [NF];
  int  m_gr [NF];
  int  m_rr [NF];
  int  m_clr_t [NF];
  int  m_clr_r [NF];
  bit  m_hs [NF];
  bit  m_issued [NR];
  int  m_fu [NR];
  int  m_lat [NR];
  bit  row_alloc [NR];
  int  m_fq [$];
  bit  m_free_en;
  int  m_free_row;
  int  m_found;

  task automatic model_step();
    if (rst || flush) begin
      if (rst) m_on = 1'b1;
      for (int f = 0; f < NF; f++) begin
        m_gv[f] = 0; m_gr[f] = 0; m_rr[f] = 0; m_clr_t[f] = -1000; m_clr_r[f] = 0;
      end
      for (int r = 0; r < NR; r++) begin
        m_issued[r] = 0; m_fu[r] = 0; m_lat[r] = 0; row_alloc[r] = 0;
      end
      m_fq.delete();
      m_free_en = 0;
      m_free_row = 0;
    end else if (m_on) begin
      if (m_fq.size() > 0) begin
        m_free_en = 1;
        m_free_row = m_fq.pop_front();
        row_alloc[m_free_row] = 0;
      end else begin
        m_free_en = 0;
      end
      for (int f = 0; f < NF; f++) m_hs[f] = m_gv[f] && fu_ready[f];
      for (int f = 0; f < NF; f++) begin
        if (m_hs[f]) begin
          m_fq.push_back(m_gr[f]);
          m_clr_t[f] = m_cyc + m_lat[m_gr[f]];
          m_clr_r[f] = m_gr[f];
        end
      end
      for (int f = 0; f < NF; f++) begin
        m_found = -1;
        for (int i = 0; i < NR; i++) begin
          int r;
          r = (m_rr[f] + i) % NR;
          if (m_found < 0 && request_vector[r] && !m_issued[r] && m_fu[r] == f) m_found = r;
        end
        if ((!m_gv[f] || m_hs[f]) && m_clr_t[f] <= m_cyc + 1 && m_found >= 0) begin
          m_gv[f] = 1;
          m_gr[f] = m_found;
          m_issued[m_found] = 1;
          m_rr[f] = (m_found + 1) % NR;
        end else if (m_hs[f]) begin
          m_gv[f] = 0;
        end
      end
      if (alloc_en) begin
        m_fu[alloc_row] = int'(alloc_fu);
        m_lat[alloc_row] = (alloc_lat == 0) ? 1 : int'(alloc_lat);
        m_issued[alloc_row] = 0;
        row_alloc[alloc_row] = 1;
      end
    end
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic [NF-1:0] e_gv;
  logic [NR-1:0] e_clr;

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      e_gv = '0;
      e_clr = '0;
      for (int f = 0; f < NF; f++) begin
        e_gv[f] = m_gv[f];
        if (m_clr_t[f] == m_cyc) e_clr[m_clr_r[f]] = 1'b1;
      end
      chk("model_grant_valid", 32'(grant_valid), 32'(e_gv));
      for (int f = 0; f < NF; f++)
        if (m_gv[f]) chk("model_grant_row", 32'(grant_row[f]), 32'(m_gr[f]));
      chk("model_clear_lines", 32'(clear_lines), 32'(e_clr));
      chk("model_clear_en", 32'(clear_en), 32'(|e_clr));
      chk("model_free_en", 32'(free_en), 32'(m_free_en));
      if (m_free_en) chk("model_free_row", 32'(free_row_index), 32'(m_free_row));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int row, input int fu, input int lat);
    alloc_en  = 1'b1;
    alloc_row = RW'(row);
    alloc_fu  = fu_id_t'(fu);
    alloc_lat = LW'(lat);
    tick();
    alloc_en  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_en = 1'b0; alloc_row = '0; alloc_fu = '0;
    alloc_lat = '0; request_vector = '0; fu_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fu_ready = '1;
    chk("reset_grant_valid", 32'(grant_valid), 32'h0);
    chk("reset_clear_lines", 32'(clear_lines), 32'h0);
    chk("reset_free_en", 32'(free_en), 32'h0);

    // Scenario 1: row 3 on FU0, latency 2
    do_alloc(3, 0, 2);
    request_vector = 8'h08;
    tick();
    chk("s1_grant_valid0", 32'(grant_valid[0]), 32'h1);
    chk("s1_grant_row0", 32'(grant_row[0]), 32'h3);
    request_vector = 8'h00;
    tick();
    tick();
    chk("s1_clear_lines", 32'(clear_lines), 32'h08);
    chk("s1_free_en", 32'(free_en), 32'h1);
    chk("s1_free_row", 32'(free_row_index), 32'h3);
    repeat (3) tick();

    // Scenario 2: rows 1,2,5 on FU1, round-robin order and wrap
    do_alloc(1, 1, 1);
    do_alloc(2, 1, 1);
    do_alloc(5, 1, 1);
    request_vector = 8'h26;
    tick();
    chk("s2_first_row", 32'(grant_row[1]), 32'h1);
    tick();
    chk("s2_second_row", 32'(grant_row[1]), 32'h2);
    tick();
    chk("s2_third_row", 32'(grant_row[1]), 32'h5);
    alloc_en = 1'b1; alloc_row = 3'd1; alloc_fu = fu_id_t'(1); alloc_lat = 8'd1;
    tick();
    alloc_en = 1'b0;
    chk("s2_gap_valid", 32'(grant_valid[1]), 32'h0);
    tick();
    chk("s2_wrap_valid", 32'(grant_valid[1]), 32'h1);
    chk("s2_wrap_row", 32'(grant_row[1]), 32'h1);
    request_vector = 8'h00;
    repeat (4) tick();

    // Scenario 3: FU2 stalls for five cycles
    fu_ready = 4'b1011;
    do_alloc(4, 2, 1);
    request_vector = 8'h10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s3_hold_valid", 32'(grant_valid[2]), 32'h1);
      chk("s3_hold_row", 32'(grant_row[2]), 32'h4);
      tick();
    end
    fu_ready = '1;
    tick();
    chk("s3_drop_valid", 32'(grant_valid[2]), 32'h0);
    chk("s3_clear", 32'(clear_lines), 32'h10);
    request_vector = 8'h00;
    repeat (4) tick();

    // Scenario 5: back-to-back on FU0 gated by the latency counter
    do_alloc(1, 0, 3);
    do_alloc(2, 0, 1);
    request_vector = 8'h06;
    tick();
    chk("s5_first_row", 32'(grant_row[0]), 32'h1);
    tick();
    chk("s5_wait_a", 32'(grant_valid[0]), 32'h0);
    tick();
    chk("s5_wait_b", 32'(grant_valid[0]), 32'h0);
    tick();
    chk("s5_second_valid", 32'(grant_valid[0]), 32'h1);
    chk("s5_second_row", 32'(grant_row[0]), 32'h2);
    chk("s5_clear_row1", 32'(clear_lines), 32'h02);
    request_vector = 8'h00;
    tick();
    chk("s5_clear_row2", 32'(clear_lines), 32'h04);
    repeat (5) tick();

    // Scenario 4: all four FUs handshake together
    do_alloc(0, 0, 2);
    do_alloc(2, 1, 2);
    do_alloc(4, 2, 3);
    do_alloc(6, 3, 3);
    request_vector = 8'h55;
    tick();
    chk("s4_all_valid", 32'(grant_valid), 32'hF);
    chk("s4_rows", 32'(grant_row), {20'h0, 3'd6, 3'd4, 3'd2, 3'd0});
    request_vector = 8'h00;
    tick();
    chk("s4_free_idle", 32'(free_en), 32'h0);
    tick();
    chk("s4_clear_a", 32'(clear_lines), 32'h05);
    chk("s4_free0", {31'h0, free_en, 28'h0, 1'b0, free_row_index} >> 0, {31'h0, 1'b1, 32'h0} >> 0);
    tick();
    chk("s4_clear_b", 32'(clear_lines), 32'h50);
    chk("s4_free2", 32'({free_en, free_row_index}), 32'h0A);
    tick();
    chk("s4_free4", 32'({free_en, free_row_index}), 32'h0C);
    tick();
    chk("s4_free6", 32'({free_en, free_row_index}), 32'h0E);
    tick();
    chk("s4_free_done", 32'(free_en), 32'h0);
    repeat (3) tick();

    // Scenario 6: flush with two grants pending and a counter running
    do_alloc(0, 0, 5);
    do_alloc(3, 1, 1);
    do_alloc(6, 2, 1);
    fu_ready = 4'b0001;
    request_vector = 8'h49;
    tick();
    request_vector = 8'h00;
    tick();
    chk("s6_pending", 32'(grant_valid), 32'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fu_ready = '1;
    chk("s6_flush_valid", 32'(grant_valid), 32'h0);
    chk("s6_flush_clear", 32'(clear_lines), 32'h0);
    chk("s6_flush_free", 32'(free_en), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("s6_quiet", 32'({clear_en, free_en, clear_lines}), 32'h0);
      tick();
    end
    do_alloc(5, 3, 2);
    request_vector = 8'h20;
    tick();
    chk("s6_after_valid", 32'(grant_valid[3]), 32'h1);
    chk("s6_after_row", 32'(grant_row[3]), 32'h5);
    request_vector = 8'h00;
    repeat (4) tick();

    // Random traffic against the model
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int start;
      int sel;
      logic [NR-1:0] mask;
      flush = ($urandom_range(0, 249) == 0);
      alloc_en = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        start = $urandom_range(0, NR - 1);
        sel = -1;
        for (int i = 0; i < NR; i++)
          if (sel < 0 && !row_alloc[(start + i) % NR]) sel = (start + i) % NR;
        if (sel >= 0) begin
          alloc_en  = 1'b1;
          alloc_row = RW'(sel);
          alloc_fu  = fu_id_t'($urandom_range(0, NF - 1));
          alloc_lat = LW'($urandom_range(0, 6));
        end
      end
      mask = '0;
      for (int r = 0; r < NR; r++) mask[r] = row_alloc[r];
      request_vector = NR'($urandom) & mask;
      fu_ready = ($urandom_range(0, 3) == 0) ? '1 : NF'($urandom);
      tick();
    end
    flush = 1'b0;
    alloc_en = 1'b0;
    request_vector = '0;
    fu_ready = '1;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
